// File: rtl/sprite_pkg.sv
// Shared sprite definitions used by the loader, the ROM reader and the renderer.
package sprite_pkg;
  localparam int PIX_W       = 12;
  localparam int DEF_SPR_W   = 32;
  localparam int DEF_SPR_H   = 32;
  localparam int DEF_NUM_OBJ = 4;
  localparam int IDX_W       = 3;

  typedef logic [PIX_W-1:0] colour_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_e;

  // Slot 0 means "no object", so legal slots are 1..num_obj.
  function automatic logic index_legal(input logic [IDX_W-1:0] idx, input int num_obj);
    return (idx != '0) && (int'(idx) <= num_obj);
  endfunction
endpackage

// File: rtl/sprite_rom_loader_if.sv
// Pixel stream in and sprite-memory write port out of the loader.
interface sprite_rom_loader_if #(
  parameter int PIX_W = 12,
  parameter int ROW_W = 5,
  parameter int COL_W = 5
);
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             wr_en;
  logic [2:0]       wr_index;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [PIX_W-1:0] wr_data;

  modport master (
    input  pix_data, pix_valid,
    output pix_ready, wr_en, wr_index, wr_row, wr_col, wr_data
  );

  modport slave (
    output pix_data, pix_valid,
    input  pix_ready, wr_en, wr_index, wr_row, wr_col, wr_data
  );
endinterface

// File: rtl/sprite_addr_counter.sv
// Raster row/col counter, column fastest, with clear, enable and last-position flag.
module sprite_addr_counter #(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int ROW_W = $clog2(SPR_H),
  parameter int COL_W = $clog2(SPR_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);
  logic col_end;

  assign col_end = (col == COL_W'(SPR_W - 1));
  assign last    = col_end && (row == ROW_W'(SPR_H - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (last) begin
        row <= '0;
        col <= '0;
      end else if (col_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_rom_loader.sv
// Sequences a valid/ready pixel stream into one object slot's sprite memory in raster order.
// state | meaning
// IDLE  | waiting for a start with a legal object index
// LOAD  | accepting pixels until the last raster position or abort
module sprite_rom_loader #(
  parameter int SPR_W   = sprite_pkg::DEF_SPR_W,
  parameter int SPR_H   = sprite_pkg::DEF_SPR_H,
  parameter int PIX_W   = sprite_pkg::PIX_W,
  parameter int NUM_OBJ = sprite_pkg::DEF_NUM_OBJ
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [sprite_pkg::IDX_W-1:0]   obj_index,
  input  logic                           abort,
  sprite_rom_loader_if.master            bus,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);
  import sprite_pkg::*;

  localparam int ROW_W = $clog2(SPR_H);
  localparam int COL_W = $clog2(SPR_W);

  load_state_e      state_q, state_d;
  logic             in_idle, in_load;
  logic             start_ok, start_bad, accept, ctr_clear, last;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = LOAD;
      LOAD: if (abort || (accept && last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_idle       = (state_q == IDLE);
    in_load       = (state_q == LOAD);
    busy          = in_load;
    bus.pix_ready = in_load && !abort;
    accept        = bus.pix_valid && bus.pix_ready;
    start_ok      = in_idle && start && index_legal(obj_index, NUM_OBJ);
    start_bad     = in_idle && start && !index_legal(obj_index, NUM_OBJ);
    // Clearing on abort keeps the next load independent of a cancelled one.
    ctr_clear     = start_ok || (in_load && abort);
  end

  sprite_addr_counter #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_addr (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (ctr_clear),
    .en     (accept),
    .row    (row),
    .col    (col),
    .last   (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_index <= '0;
      bus.wr_row   <= '0;
      bus.wr_col   <= '0;
      bus.wr_data  <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      if (start_ok) idx_q <= obj_index;
      bus.wr_en <= accept;
      done      <= accept && last;
      error     <= start_bad;
      if (accept) begin
        bus.wr_index <= idx_q;
        bus.wr_row   <= row;
        bus.wr_col   <= col;
        bus.wr_data  <= bus.pix_data;
      end
    end
  end
endmodule

// File: tb/tb_sprite_rom_loader.sv
// Randomized and directed checks of the sprite loader against a raster-position scoreboard model.
module tb_sprite_rom_loader;
  localparam int SPR_W = 4;
  localparam int SPR_H = 2;
  localparam int NUM_OBJ = 4;
  localparam int NPIX = SPR_W * SPR_H;
  localparam int ROW_W = $clog2(SPR_H);
  localparam int COL_W = $clog2(SPR_W);

  logic clk = 1'b0;
  logic reset_n, start, abort, busy, done, error;
  logic [2:0] obj_index;

  sprite_rom_loader_if #(.PIX_W(12), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  sprite_rom_loader #(.SPR_W(SPR_W), .SPR_H(SPR_H), .PIX_W(12), .NUM_OBJ(NUM_OBJ)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .obj_index(obj_index), .abort(abort),
    .bus(bus), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: loading flag, linear pixel position, latched slot, last written values.
  bit               m_loading;
  int               m_pos;
  logic [2:0]       m_idx;
  logic [ROW_W-1:0] h_row;
  logic [COL_W-1:0] h_col;
  logic [11:0]      h_data;
  logic [2:0]       h_idx;
  int               n_wr, n_done, n_err;

  task automatic model_reset();
    m_loading = 0; m_pos = 0; m_idx = '0;
    h_row = '0; h_col = '0; h_data = '0; h_idx = '0;
  endtask

  task automatic drive_cycle(input logic s, input logic [2:0] oi, input logic ab,
                             input logic v, input logic [11:0] d);
    bit acc, was_loading, legal, e_wr, e_done, e_err;
    start = s; obj_index = oi; abort = ab; bus.pix_valid = v; bus.pix_data = d;
    #1;
    vectors++;
    if (bus.pix_ready !== (m_loading && !ab)) begin
      miscompares++;
      $display("FAIL pix_ready got %b want %b", bus.pix_ready, m_loading && !ab);
    end
    was_loading = m_loading;
    acc = m_loading && !ab && v;
    e_wr = acc; e_done = 0; e_err = 0;
    if (acc) begin
      h_row = ROW_W'(m_pos / SPR_W);
      h_col = COL_W'(m_pos % SPR_W);
      h_data = d; h_idx = m_idx;
      n_wr++; m_pos++;
      if (m_pos == NPIX) begin
        e_done = 1; n_done++; m_loading = 0; m_pos = 0;
      end
    end else if (m_loading && ab) begin
      m_loading = 0; m_pos = 0;
    end
    legal = (oi >= 1) && (oi <= NUM_OBJ);
    if (!was_loading && s) begin
      if (legal) begin m_loading = 1; m_idx = oi; m_pos = 0; end
      else begin e_err = 1; n_err++; end
    end
    @(posedge clk); #1;
    vectors += 5;
    if (bus.wr_en !== e_wr) begin miscompares++; $display("FAIL wr_en got %b want %b", bus.wr_en, e_wr); end
    if (done !== e_done) begin miscompares++; $display("FAIL done got %b want %b", done, e_done); end
    if (error !== e_err) begin miscompares++; $display("FAIL error got %b want %b", error, e_err); end
    if (busy !== m_loading) begin miscompares++; $display("FAIL busy got %b want %b", busy, m_loading); end
    if ({bus.wr_index, bus.wr_row, bus.wr_col, bus.wr_data} !== {h_idx, h_row, h_col, h_data}) begin
      miscompares++;
      $display("FAIL wr_port got idx=%0d row=%0d col=%0d data=%h want idx=%0d row=%0d col=%0d data=%h",
               bus.wr_index, bus.wr_row, bus.wr_col, bus.wr_data, h_idx, h_row, h_col, h_data);
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({bus.pix_ready, bus.wr_en, bus.wr_index, bus.wr_row, bus.wr_col, bus.wr_data, busy, done, error} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs got rdy=%b en=%b idx=%0d row=%0d col=%0d data=%h busy=%b done=%b err=%b want all 0",
               tag, bus.pix_ready, bus.wr_en, bus.wr_index, bus.wr_row, bus.wr_col, bus.wr_data, busy, done, error);
    end
  endtask

  task automatic idle_inputs();
    start = 0; obj_index = '0; abort = 0; bus.pix_valid = 0; bus.pix_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    check_all_zero("after_release");
  endtask

  task automatic test_full_load();
    int w0 = n_wr, d0 = n_done;
    drive_cycle(1, 3'd2, 0, 0, '0);
    for (int i = 1; i <= NPIX; i++) drive_cycle(0, '0, 0, 1, 12'(i));
    drive_cycle(0, '0, 0, 0, '0);
    vectors += 2;
    if (n_wr - w0 != NPIX) begin miscompares++; $display("FAIL full_writes got %0d want %0d", n_wr - w0, NPIX); end
    if (n_done - d0 != 1) begin miscompares++; $display("FAIL full_done got %0d want 1", n_done - d0); end
  endtask

  task automatic test_illegal();
    int e0 = n_err, w0 = n_wr;
    drive_cycle(1, 3'd0, 0, 1, 12'h111);
    drive_cycle(0, '0, 0, 1, 12'h222);
    drive_cycle(1, 3'd5, 0, 1, 12'h333);
    drive_cycle(0, '0, 0, 1, 12'h444);
    drive_cycle(1, 3'd7, 1, 1, 12'h555);
    drive_cycle(0, '0, 0, 0, '0);
    vectors += 2;
    if (n_err - e0 != 3) begin miscompares++; $display("FAIL illegal_errors got %0d want 3", n_err - e0); end
    if (n_wr != w0) begin miscompares++; $display("FAIL illegal_writes got %0d want 0", n_wr - w0); end
  endtask

  task automatic test_backpressure();
    int w0 = n_wr, d0 = n_done, k = 0;
    logic [3:0] pat = 4'b1001;
    drive_cycle(1, 3'd1, 0, 0, '0);
    for (int c = 0; c < 200 && (n_wr - w0) < NPIX; c++) begin
      drive_cycle(0, '0, 0, pat[k % 4], 12'($urandom_range(0, 4095)));
      k++;
    end
    drive_cycle(0, '0, 0, 0, '0);
    vectors += 2;
    if (n_wr - w0 != NPIX) begin miscompares++; $display("FAIL bp_writes got %0d want %0d", n_wr - w0, NPIX); end
    if (n_done - d0 != 1) begin miscompares++; $display("FAIL bp_done got %0d want 1", n_done - d0); end
  endtask

  task automatic test_abort();
    int w0 = n_wr, d0 = n_done;
    drive_cycle(1, 3'($urandom_range(1, NUM_OBJ)), 0, 0, '0);
    for (int i = 0; i < 3; i++) drive_cycle(0, '0, 0, 1, 12'($urandom_range(0, 4095)));
    drive_cycle(0, '0, 1, 1, 12'hABC);
    for (int i = 0; i < 3; i++) drive_cycle(0, '0, 0, 1, 12'hDEF);
    vectors += 3;
    if (n_wr - w0 != 3) begin miscompares++; $display("FAIL abort_writes got %0d want 3", n_wr - w0); end
    if (n_done != d0) begin miscompares++; $display("FAIL abort_done got %0d want 0", n_done - d0); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_load();
    drive_cycle(1, 3'd3, 0, 0, '0);
    for (int i = 0; i < 5; i++) drive_cycle(0, '0, 0, 1, 12'($urandom_range(1, 4095)));
    #2 reset_n = 0;
    idle_inputs();
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    drive_cycle(1, 3'd1, 0, 0, '0);
    drive_cycle(0, '0, 0, 1, 12'h5A5);
    vectors++;
    if ({bus.wr_en, bus.wr_index, bus.wr_row, bus.wr_col} !== {1'b1, 3'd1, {ROW_W{1'b0}}, {COL_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL restart_pos got en=%b idx=%0d row=%0d col=%0d want en=1 idx=1 row=0 col=0",
               bus.wr_en, bus.wr_index, bus.wr_row, bus.wr_col);
    end
    for (int i = 1; i < NPIX; i++) drive_cycle(0, '0, 0, 1, 12'($urandom_range(0, 4095)));
  endtask

  task automatic test_back_to_back();
    int e0 = n_err;
    drive_cycle(1, 3'd3, 0, 0, '0);
    for (int i = 0; i < NPIX; i++)
      drive_cycle(i == 2 || i == 4, (i == 2) ? 3'd2 : 3'd0, 0, 1, 12'($urandom_range(0, 4095)));
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done got %b want 1", done); end
    drive_cycle(1, 3'd4, 0, 0, '0);
    for (int i = 0; i < NPIX; i++) drive_cycle(0, '0, 0, 1, 12'($urandom_range(0, 4095)));
    drive_cycle(0, '0, 0, 0, '0);
    vectors++;
    if (n_err != e0) begin miscompares++; $display("FAIL b2b_errors got %0d want 0", n_err - e0); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++)
      drive_cycle($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, 12'($urandom_range(0, 4095)));
  endtask

  initial begin
    n_wr = 0; n_done = 0; n_err = 0;
    test_reset();
    test_full_load();
    test_illegal();
    test_backpressure();
    test_abort();
    test_reset_mid_load();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sprite_rom_loader.md
Name: sprite_rom_loader

Overview:
- Write-side companion to the per-object sprite colour ROM reader.
- Accepts a valid/ready stream of 12-bit colour pixels and sequences them into sprite memory for one object slot, in raster order: row-major, column fastest.
- Sits between the asset source (UART/host loader) and the object sprite RAMs, which the renderer later reads by index/row/col.
- Produces a registered write port plus start/busy/done/error control.

Parameters:
- SPR_W, 32, sprite width in pixels (columns per row), >=2.
- SPR_H, 32, sprite height in pixels (rows), >=2.
- PIX_W, 12, colour word width (4:4:4 RGB).
- NUM_OBJ, 4, number of valid object slots; legal indices are 1..NUM_OBJ, and 0 means "no object".

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin loading a sprite.
- obj_index  in  3  target object slot, sampled on accepted start.
- abort  in  1  cancel an in-progress load.
- pix_data  in  PIX_W  incoming colour word.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  loader accepts a beat this cycle.
- wr_en  out  1  write strobe to sprite memory.
- wr_index  out  3  object slot being written.
- wr_row  out  clog2(SPR_H)  row address.
- wr_col  out  clog2(SPR_W)  column address.
- wr_data  out  PIX_W  colour word to write.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse: last pixel written.
- error  out  1  one-cycle pulse: start rejected due to an illegal index.

Behaviour:
- Reset (async assert, sync release): state IDLE, and all outputs are 0 (pix_ready, wr_en, wr_index, wr_row, wr_col, wr_data, busy, done, error). Internal row/col counters are 0.
- States: IDLE, LOAD.
- IDLE, start=1, obj_index in 1..NUM_OBJ:
  - Latch the index and clear the counters.
  - Go to LOAD next cycle; busy=1 from that cycle.
- IDLE, start=1, obj_index=0 or >NUM_OBJ:
  - Stay in IDLE.
  - error=1 in the next cycle, for exactly one cycle.
- LOAD:
  - pix_ready = (state==LOAD) & ~abort. This is combinational; no other dependency.
  - A beat is accepted when pix_valid & pix_ready.
  - Write latency is 1 cycle. For a beat accepted in cycle N, cycle N+1 shows wr_en=1 with wr_data=pix_data, wr_row/wr_col equal to that beat's position, and wr_index equal to the latched index.
  - wr_en is 0 in any cycle not following an accepted beat. wr_row, wr_col, wr_data and wr_index hold their last values when wr_en=0.
  - Counter advance: col+1. At col=SPR_W-1, col wraps to 0 and row increments.
  - Last beat (row=SPR_H-1, col=SPR_W-1) accepted in cycle N:
    - In cycle N+1: wr_en=1 for that pixel, done=1, busy=0, state IDLE, pix_ready=0.
    - Counters return to 0.
  - pix_valid gaps: the counters and position hold. No timeout.
- start while busy is ignored, with no error pulse.
- abort=1 in LOAD:
  - No beat is accepted that cycle.
  - Next cycle: IDLE, busy=0, no done.
  - A write from a beat accepted in the previous cycle still completes (wr_en=1).
  - Already-written memory is not rolled back.
- abort in IDLE: no effect. abort and start in the same IDLE cycle: start wins, and abort is ignored.
- reset_n low mid-load: immediate return to the reset state. Any pending write is dropped.
- Back-to-back: start may be asserted in the same cycle done pulses; that start is accepted because the state is already IDLE.

Decomposition:
- Shared package sprite_pkg holds:
  - PIX_W, the default SPR_W/SPR_H and NUM_OBJ.
  - The state enum (IDLE, LOAD).
  - A colour-word typedef.
- All of these are shared with the ROM reader and the renderer.
- One natural sub-module: sprite_addr_counter. It implements the row/col raster counter with enable, clear and last flag, and can be reused by the reader-side scanout.

Test Plan (SPR_W=4, SPR_H=2, NUM_OBJ=4):
- Full load: start, obj_index=2; 8 beats on consecutive cycles with data 0x001..0x008. Expect wr_en for 8 cycles with (row,col) = (0,0),(0,1),(0,2),(0,3),(1,0)..(1,3), wr_index=2, and done coinciding with the write of 0x008 at (1,3). busy then drops.
- Illegal index: start with obj_index=0, then with obj_index=5. Expect one error pulse each, busy never asserts, and no wr_en.
- Backpressure: valid toggles 1,0,0,1 across beats. Expect no wr_en in gap cycles, addresses contiguous with no skipped position, and a total of 8 writes.
- Abort: abort asserted after 3 accepted beats, with pix_valid held at 1. Expect 3 writes only, pix_ready=0 in the abort cycle, busy=0 next cycle, and no done.
- Reset mid-load: reset_n low after 5 beats. Expect all outputs 0 immediately. After release, start with obj_index=1 restarts at (0,0).
- Back-to-back: start with obj_index=4 in the done cycle of the obj_index=3 load. Expect the second load to begin at (0,0) with wr_index=4, and start to be ignored while busy.
